// File: rtl/aes_dec_arb_pkg.sv
// Shared constants and FSM state type for the AES decryptor arbiter.
package aes_dec_arb_pkg;

  localparam int unsigned AES_BLK_W       = 128;
  localparam int unsigned DEF_NUM_REQ     = 2;
  localparam int unsigned DEF_TIMEOUT_CYC = 64;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StDeliver
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request searching upward from last_grant+1.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  localparam int unsigned IDX_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid
);

  // Scan all requesters once, starting just after the previous winner.
  always_comb begin
    int unsigned idx;
    idx         = 0;
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = 32'(last_grant) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grant_valid && req[idx[IDX_W-1:0]]) begin
        grant_valid             = 1'b1;
        grant_idx               = idx[IDX_W-1:0];
        grant[idx[IDX_W-1:0]]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/aes_dec_arbiter.sv
// Shares one AES decryptor core among NUM_REQ requesters, one block in flight at a time.
// Optional result timeout in DELIVER is built when AES_DEC_ARB_TIMEOUT_EN is defined.
module aes_dec_arbiter
  import aes_dec_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ     = DEF_NUM_REQ,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*AES_BLK_W-1:0]   req_data,
  input  logic [NUM_REQ*AES_BLK_W-1:0]   req_key,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             resp_valid,
  output logic [AES_BLK_W-1:0]           resp_data,
  input  logic [NUM_REQ-1:0]             resp_ready,
  output logic [NUM_REQ-1:0]             err_timeout,
  output logic [AES_BLK_W-1:0]           core_datain,
  output logic [AES_BLK_W-1:0]           core_key,
  output logic                           core_dat_stb,
  output logic                           core_key_valid,
  input  logic                           core_ready,
  input  logic [AES_BLK_W-1:0]           core_dataout,
  input  logic                           core_o_valid,
  output logic                           core_o_stb
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  arb_state_e             state_q, state_d;
  logic [IDX_W-1:0]       owner_q, owner_d;
  logic [IDX_W-1:0]       last_grant_q, last_grant_d;
  logic [AES_BLK_W-1:0]   resp_data_q, resp_data_d;
  logic [NUM_REQ-1:0]     grant;
  logic [IDX_W-1:0]       grant_idx;
  logic                   grant_valid;
  logic                   timeout_hit;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req         (req_valid),
    .last_grant  (last_grant_q),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // One-hot grant is informational only; the index drives the owner register.
  logic unused_grant;
  assign unused_grant = ^grant;

`ifdef AES_DEC_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counts DELIVER cycles; restarts whenever the FSM leaves DELIVER.
  always_comb begin
    cnt_d = '0;
    if (state_q == StDeliver && state_d == StDeliver) cnt_d = cnt_q + 1'b1;
  end

  // Timeout counter register.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`else
  // DELIVER waits forever in this build.
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;
  assign timeout_hit    = 1'b0;
`endif

  // Next-state and output decode; all outputs idle at 0 unless the state drives them.
  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    last_grant_d   = last_grant_q;
    resp_data_d    = resp_data_q;
    req_ready      = '0;
    resp_valid     = '0;
    err_timeout    = '0;
    core_dat_stb   = 1'b0;
    core_key_valid = 1'b0;
    core_datain    = '0;
    core_key       = '0;
    core_o_stb     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (grant_valid) begin
          owner_d = grant_idx;
          state_d = StIssue;
        end
      end
      StIssue: begin
        core_dat_stb   = 1'b1;
        core_key_valid = 1'b1;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
          if (owner_q == i[IDX_W-1:0]) begin
            core_datain = req_data[i*AES_BLK_W +: AES_BLK_W];
            core_key    = req_key[i*AES_BLK_W +: AES_BLK_W];
          end
        end
        if (core_ready) begin
          req_ready[owner_q] = 1'b1;
          state_d            = StWait;
        end
      end
      StWait: begin
        if (core_o_valid) begin
          core_o_stb  = 1'b1;
          resp_data_d = core_dataout;
          state_d     = StDeliver;
        end
      end
      StDeliver: begin
        resp_valid[owner_q] = 1'b1;
        if (resp_ready[owner_q]) begin
          last_grant_d = owner_q;
          state_d      = StIdle;
        end else if (timeout_hit) begin
          err_timeout[owner_q] = 1'b1;
          last_grant_d         = owner_q;
          state_d              = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset makes requester 0 the first winner.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      owner_q      <= '0;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      resp_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      resp_data_q  <= resp_data_d;
    end
  end

  assign resp_data = resp_data_q;

endmodule

// File: tb/tb_aes_dec_arbiter.sv
// Self-checking bench for aes_dec_arbiter with a behavioural fixed-latency core model.
// Define AES_DEC_ARB_TIMEOUT_EN to also exercise the result timeout.
`timescale 1ns/1ps
module tb_aes_dec_arbiter;
  import aes_dec_arb_pkg::*;

  localparam int N       = 2;
  localparam int TO      = 8;
  localparam int CoreLat = 3;
`ifdef AES_DEC_ARB_TIMEOUT_EN
  localparam int HoldCyc = 5;
`else
  localparam int HoldCyc = 10;
`endif

  localparam logic [127:0] FipsKey = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FipsCt  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] FipsPt  = 128'h00112233445566778899aabbccddeeff;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     req_valid;
  logic [N*128-1:0] req_data, req_key;
  logic [N-1:0]     req_ready, resp_valid, resp_ready, err_timeout;
  logic [127:0]     resp_data, core_datain, core_key, core_dataout;
  logic             core_dat_stb, core_key_valid, core_ready, core_o_valid, core_o_stb;

  logic [127:0] ct_r [N];
  logic [127:0] key_r [N];
  assign req_data = {ct_r[1], ct_r[0]};
  assign req_key  = {key_r[1], key_r[0]};

  always #5 clk = ~clk;

  aes_dec_arbiter #(
    .NUM_REQ     (N),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_data       (req_data),
    .req_key        (req_key),
    .req_ready      (req_ready),
    .resp_valid     (resp_valid),
    .resp_data      (resp_data),
    .resp_ready     (resp_ready),
    .err_timeout    (err_timeout),
    .core_datain    (core_datain),
    .core_key       (core_key),
    .core_dat_stb   (core_dat_stb),
    .core_key_valid (core_key_valid),
    .core_ready     (core_ready),
    .core_dataout   (core_dataout),
    .core_o_valid   (core_o_valid),
    .core_o_stb     (core_o_stb)
  );

  // Reference core function: golden FIPS-197 vector, otherwise a keyed scramble.
  function automatic logic [127:0] core_fn(input logic [127:0] ct, input logic [127:0] key);
    if (ct == FipsCt && key == FipsKey) return FipsPt;
    return ct ^ {key[63:0], key[127:64]};
  endfunction

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Core model: accepts a block when idle, answers CoreLat cycles later.
  logic         core_stall;
  logic         c_busy;
  int           c_cnt;
  logic [127:0] c_res;
  assign core_ready   = !c_busy && !core_o_valid && !core_stall;
  assign core_dataout = c_res;

  always @(posedge clk) begin
    if (reset) begin
      c_busy       <= 1'b0;
      c_cnt        <= 0;
      c_res        <= '0;
      core_o_valid <= 1'b0;
    end else begin
      if (core_o_valid && core_o_stb) core_o_valid <= 1'b0;
      if (!c_busy && core_dat_stb && core_ready) begin
        c_busy <= 1'b1;
        c_cnt  <= CoreLat;
        c_res  <= core_fn(core_datain, core_key);
      end else if (c_busy) begin
        if (c_cnt == 1) begin
          core_o_valid <= 1'b1;
          c_busy       <= 1'b0;
        end
        c_cnt <= c_cnt - 1;
      end
    end
  end

  typedef struct {
    int           owner;
    logic [127:0] data;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    logic [N-1:0] vld;
    int           owner;
    int           hold;
    logic [N-1:0] hold_vld;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Wait for the acceptance pulse, check what is driven to the core, record the expected result.
  task automatic wait_grant(input int exp_owner);
    int n;
    n = 0;
    while (req_ready == '0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("grant_seen", 128'(n < 50), 128'(1));
    check("req_ready", 128'(req_ready), 128'(onehot(exp_owner)));
    check("core_datain", core_datain, ct_r[exp_owner]);
    check("core_key", core_key, key_r[exp_owner]);
    check("core_strobes", 128'({core_dat_stb, core_key_valid}), 128'(2'b11));
    sb.push_back('{exp_owner, core_fn(ct_r[exp_owner], key_r[exp_owner])});
    @(negedge clk);
    req_valid[exp_owner] = 1'b0;
  endtask

  // Wait for the result, compare against the scoreboard, optionally stall, then accept.
  task automatic wait_resp(input int exp_owner, input int hold, input logic [N-1:0] hold_vld);
    int n, stb, rdy, bad;
    sb_t e;
    logic [127:0] d0;
    n = 0; stb = 0; rdy = 0; bad = 0;
    while (resp_valid == '0 && n < 100) begin
      if (core_o_stb) stb++;
      if (req_ready != '0) rdy++;
      @(negedge clk);
      n++;
    end
    check("resp_latency", 128'(n), 128'(CoreLat + 1));
    check("core_o_stb_count", 128'(stb), 128'(1));
    check("no_extra_req_ready", 128'(rdy), 128'(0));
    check("resp_valid", 128'(resp_valid), 128'(onehot(exp_owner)));
    if (sb.size() == 0) begin
      check("scoreboard_empty", 128'(0), 128'(1));
    end else begin
      e = sb.pop_front();
      check("resp_owner", 128'(exp_owner), 128'(e.owner));
      check("resp_data", resp_data, e.data);
    end
    d0 = resp_data;
    req_valid = req_valid | hold_vld;
    resp_ready = ~onehot(exp_owner);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (resp_valid !== onehot(exp_owner) || resp_data !== d0 || core_dat_stb !== 1'b0 ||
          req_ready !== '0 || err_timeout !== '0) bad++;
    end
    check("hold_stable", 128'(bad), 128'(0));
    resp_ready = onehot(exp_owner);
    @(negedge clk);
    resp_ready = '0;
    check("resp_cleared", 128'({resp_valid, err_timeout}), 128'(0));
  endtask

  vec_t tbl[9];

  initial begin
    int n, bad, hit, pulses;
    logic [N-1:0] errv, rv_after;

    tbl[0] = '{2'b11, 0, 0, 2'b00};
    tbl[1] = '{2'b11, 1, 0, 2'b00};
    tbl[2] = '{2'b11, 0, 0, 2'b00};
    tbl[3] = '{2'b11, 1, 0, 2'b00};
    tbl[4] = '{2'b01, 0, HoldCyc, 2'b01};
    tbl[5] = '{2'b01, 0, 0, 2'b00};
    tbl[6] = '{2'b10, 1, HoldCyc, 2'b11};
    tbl[7] = '{2'b11, 0, 0, 2'b00};
    tbl[8] = '{2'b10, 1, 0, 2'b00};

    ct_r[0]  = FipsCt;
    key_r[0] = FipsKey;
    ct_r[1]  = 128'hfedcba9876543210_0123456789abcdef;
    key_r[1] = 128'h0f1e2d3c4b5a6978_8796a5b4c3d2e1f0;

    reset = 1'b1; req_valid = '0; resp_ready = '0; core_stall = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 128'({req_ready, resp_valid, err_timeout, core_dat_stb,
                                 core_key_valid, core_o_stb}), 128'(0));
    check("reset_resp_data", resp_data, 128'(0));
    check("reset_core_bus", core_datain | core_key, 128'(0));
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      req_valid = tbl[i].vld;
      wait_grant(tbl[i].owner);
      wait_resp(tbl[i].owner, tbl[i].hold, tbl[i].hold_vld);
    end
    req_valid = '0;
    @(negedge clk);

    // Core busy while ISSUE is waiting: strobes stay up, no acceptance until core_ready.
    core_stall = 1'b1;
    req_valid  = 2'b01;
    n = 0;
    while (!core_dat_stb && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("stall_issue_seen", 128'(n < 20), 128'(1));
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!(core_dat_stb && core_key_valid) || req_ready !== '0) bad++;
    end
    check("stall_hold", 128'(bad), 128'(0));
    core_stall = 1'b0;
    #1;
    wait_grant(0);
    wait_resp(0, 0, 2'b00);

    // Reset while the block is in the core.
    req_valid = 2'b01;
    wait_grant(0);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_outputs", 128'({req_ready, resp_valid, err_timeout, core_dat_stb,
                                    core_key_valid, core_o_stb}), 128'(0));
    check("midreset_resp_data", resp_data, 128'(0));
    check("midreset_core_bus", core_datain | core_key, 128'(0));
    reset = 1'b0;
    sb.delete();
    req_valid = 2'b10;
    wait_grant(1);
    wait_resp(1, 0, 2'b00);

`ifdef AES_DEC_ARB_TIMEOUT_EN
    // Result never collected: dropped on the TO-th DELIVER cycle.
    req_valid = 2'b01;
    wait_grant(0);
    n = 0;
    while (resp_valid == '0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    hit = 0; pulses = 0; errv = '0; rv_after = '1;
    for (int k = 1; k <= TO + 2; k++) begin
      if (err_timeout != '0) begin
        pulses++;
        if (hit == 0) begin
          hit  = k;
          errv = err_timeout;
        end
      end
      if (k == TO + 1) rv_after = resp_valid;
      @(negedge clk);
    end
    check("timeout_cycle", 128'(hit), 128'(TO));
    check("timeout_pulses", 128'(pulses), 128'(1));
    check("timeout_owner", 128'(errv), 128'(2'b01));
    check("timeout_resp_cleared", 128'(rv_after), 128'(0));
    sb.delete();
    req_valid = 2'b10;
    wait_grant(1);
    wait_resp(1, 0, 2'b00);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected to finish earlier", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/aes_dec_arbiter.md
AES_DEC_ARBITER -- requirements
Module: aes_dec_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 2, number of requesters sharing one AES_decryptor core (range 2..8).
REQ-002 Parameter TIMEOUT_CYC, default 64, cycles a finished result waits for its requester before it is dropped (timeout build only).
REQ-003 clk  input  1  single clock; all logic on posedge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  NUM_REQ  per-requester block request.
REQ-006 req_data  input  NUM_REQ*128  ciphertext blocks, requester i at bits [128*i+127:128*i].
REQ-007 req_key  input  NUM_REQ*128  cipher keys, same packing.
REQ-008 req_ready  output  NUM_REQ  one-hot acceptance pulse; request i is consumed when req_valid[i] && req_ready[i].
REQ-009 resp_valid  output  NUM_REQ  one-hot, result available for the owning requester.
REQ-010 resp_data  output  128  plaintext result, valid while any resp_valid bit is high.
REQ-011 resp_ready  input  NUM_REQ  per-requester result acceptance.
REQ-012 err_timeout  output  NUM_REQ  one-cycle pulse, result for requester i dropped.
REQ-013 core_datain / core_key  output  128 each  block and key driven to the core.
REQ-014 core_dat_stb / core_key_valid  output  1 each  core start strobes, always equal.
REQ-015 core_ready  input  1  core idle.
REQ-016 core_dataout  input  128; core_o_valid  input  1; core_o_stb  output  1  core result handshake.

Function
REQ-017 FSM states IDLE, ISSUE, WAIT, DELIVER; exactly one active.
REQ-018 IDLE: if any req_valid bit is set, select the first set bit searching upward from (last_grant+1) mod NUM_REQ with wrap-around, latch it in owner, go to ISSUE; otherwise stay.
REQ-019 ISSUE: drive core_dat_stb=core_key_valid=1, core_datain/core_key = slice owner; when core_ready=1 pulse req_ready[owner] that same cycle and go to WAIT.
REQ-020 Outside ISSUE, core_dat_stb, core_key_valid and all req_ready bits are 0; core_datain and core_key hold 0.
REQ-021 A requester holds req_valid, req_data and req_key stable until accepted; deassertion before acceptance is not supported.
REQ-022 WAIT: when core_o_valid=1, register core_dataout into resp_data, drive core_o_stb=1 for exactly that cycle, go to DELIVER.
REQ-023 DELIVER: resp_valid[owner]=1; when resp_ready[owner]=1, clear resp_valid, set last_grant=owner, go to IDLE.
REQ-024 New requests are not accepted outside IDLE; at most one block is in flight.
REQ-025 resp_ready bits of non-owners are ignored; simultaneous req_valid from the owner in DELIVER waits for the next IDLE arbitration.
REQ-026 Minimum latency: acceptance to resp_valid = core latency + 1 cycle; back-to-back requests lose one IDLE cycle between blocks.

Reset
REQ-027 Reset forces IDLE, owner=0, last_grant=NUM_REQ-1 (requester 0 wins first), resp_data=0, all outputs 0, timeout counter 0.
REQ-028 Reset mid-operation abandons the in-flight block with no err_timeout pulse; the core shares the same reset.

Configuration
REQ-029 Macro AES_DEC_ARB_TIMEOUT_EN defined: a counter runs in DELIVER; when TIMEOUT_CYC cycles pass without resp_ready[owner], clear resp_valid, pulse err_timeout[owner] one cycle, set last_grant=owner, go to IDLE.
REQ-030 Macro undefined: DELIVER waits indefinitely, no counter is built, and err_timeout is tied 0.

Structure
REQ-031 Package aes_dec_arb_pkg holds the FSM state enum, AES_BLK_W=128, and the default NUM_REQ/TIMEOUT_CYC constants.
REQ-032 Sub-module rr_arbiter (combinational round-robin pick, NUM_REQ-wide request in, last_grant in, one-hot grant plus index out) is instantiated once.

Verification
REQ-033 req_valid=2'b01 with the FIPS-197 key 000102..0F and ciphertext 69C4E0D86A7B0430D8CDB78070B4C55A -> resp_valid=2'b01, resp_data matches the core's golden output, core_o_stb pulses once.
REQ-034 req_valid=2'b11 held for 4 blocks -> grant order 0,1,0,1; each requester receives its own result.
REQ-035 resp_ready[owner] held low 10 cycles -> resp_valid and resp_data stable; no new core_dat_stb until acceptance.
REQ-036 Timeout build, TIMEOUT_CYC=8, resp_ready=0 -> err_timeout[owner] pulses on cycle 8 of DELIVER, FSM back in IDLE, next request served.
REQ-037 Reset asserted in WAIT -> next cycle all outputs 0, state IDLE; a subsequent request from requester 1 alone is granted normally.
REQ-038 core_ready held low 5 cycles in ISSUE -> strobes stay high, req_ready stays 0 until core_ready rises, then exactly one req_ready pulse.
